// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types and constants for the serial sequence transmitter.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    WORD = 2'd2
  } state_t;

  localparam int         WORD_W    = 8;
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Fibonacci feedback over taps 7,5,4,3.
  function automatic logic lfsr_feedback(input logic [7:0] v);
    return ^(v & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/seq_lfsr.sv
// rtl/seq_lfsr.sv - 8-bit Fibonacci filler LFSR with synchronous seed load and advance enable.
module seq_lfsr
  import seq_pkg::*;
#(
  parameter logic [7:0] SEED = seq_pkg::LFSR_SEED
) (
  input  logic clk,
  input  logic i_load,
  input  logic i_advance,
  output logic o_bit,
  output logic o_next_bit
);

  logic [7:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (i_load) begin
      r_lfsr <= SEED;
    end else if (i_advance) begin
      r_lfsr <= {r_lfsr[6:0], lfsr_feedback(r_lfsr)};
    end
  end

  // Bit 6 becomes bit 7 after an advance, so it is the filler bit that follows.
  assign o_bit      = r_lfsr[7];
  assign o_next_bit = r_lfsr[6];

endmodule

// File: rtl/sequence_transmitter.sv
// rtl/sequence_transmitter.sv - MSB-first word transmitter with LFSR filler and valid/ready stall.
// Optional back-to-back frames while start is held: define SEQ_TX_REPEAT_EN.
module sequence_transmitter
  import seq_pkg::*;
#(
  parameter int         WORD_W    = seq_pkg::WORD_W,
  parameter int         GAP_W     = 4,
  parameter logic [7:0] LFSR_SEED = seq_pkg::LFSR_SEED
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              setar_palavra,
  input  logic [WORD_W-1:0] palavra,
  input  logic [GAP_W-1:0]  gap,
  input  logic              start,
  input  logic              bit_ready,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              busy,
  output logic              done
);

  state_t            r_state;
  logic [WORD_W-1:0] r_word;
  logic [GAP_W-1:0]  r_gap;
  logic [GAP_W-1:0]  r_gap_cnt;
  logic [2:0]        r_idx;
  logic              r_start_q;

  logic   w_xfer;
  logic   w_launch;
  logic   w_restart;
  logic   w_lfsr_adv;
  logic   w_lfsr_bit;
  logic   w_lfsr_next;
  logic   w_first_bit;
  state_t w_first_state;

  assign w_xfer        = bit_valid && bit_ready;
  assign w_launch      = start && !r_start_q;
  assign w_lfsr_adv    = (r_state == GAP) && w_xfer && !setar_palavra;
  assign w_first_state = (r_gap != '0) ? GAP : WORD;
  assign w_first_bit   = (r_gap != '0) ? w_lfsr_bit : r_word[WORD_W-1];

`ifdef SEQ_TX_REPEAT_EN
  assign w_restart = start;
`else
  assign w_restart = 1'b0;
`endif

  seq_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk        (clk),
    .i_load     (rst),
    .i_advance  (w_lfsr_adv),
    .o_bit      (w_lfsr_bit),
    .o_next_bit (w_lfsr_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_word    <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
      r_idx     <= 3'd7;
      r_start_q <= 1'b0;
      bit_out   <= 1'b0;
      bit_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      r_start_q <= start;
      done      <= 1'b0;
      if (setar_palavra) begin
        r_word    <= palavra;
        r_gap     <= gap;
        r_state   <= IDLE;
        bit_valid <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_launch) begin
              r_state   <= w_first_state;
              r_idx     <= 3'd7;
              r_gap_cnt <= r_gap;
              bit_out   <= w_first_bit;
              bit_valid <= 1'b1;
              busy      <= 1'b1;
            end
          end
          GAP: begin
            if (w_xfer) begin
              r_gap_cnt <= r_gap_cnt - 1'b1;
              if (r_gap_cnt == GAP_W'(1)) begin
                r_state <= WORD;
                bit_out <= r_word[WORD_W-1];
              end else begin
                bit_out <= w_lfsr_next;
              end
            end
          end
          WORD: begin
            if (w_xfer) begin
              if (r_idx == 3'd0) begin
                done <= 1'b1;
                // Restart keeps bit_valid high so the consumer sees no bubble.
                if (w_restart) begin
                  r_state   <= w_first_state;
                  r_idx     <= 3'd7;
                  r_gap_cnt <= r_gap;
                  bit_out   <= w_first_bit;
                end else begin
                  r_state   <= IDLE;
                  bit_valid <= 1'b0;
                  busy      <= 1'b0;
                end
              end else begin
                r_idx   <= r_idx - 3'd1;
                bit_out <= r_word[r_idx-3'd1];
              end
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sequence_transmitter.sv
// tb/tb_sequence_transmitter.sv - directed self-checking bench for sequence_transmitter.
module tb_sequence_transmitter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       setar_palavra = 1'b0;
  logic [7:0] palavra = 8'h00;
  logic [3:0] gap = 4'h0;
  logic       start = 1'b0;
  logic       bit_ready = 1'b1;
  logic       bit_out;
  logic       bit_valid;
  logic       busy;
  logic       done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sequence_transmitter dut (
    .clk          (clk),
    .rst          (rst),
    .setar_palavra(setar_palavra),
    .palavra      (palavra),
    .gap          (gap),
    .start        (start),
    .bit_ready    (bit_ready),
    .bit_out      (bit_out),
    .bit_valid    (bit_valid),
    .busy         (busy),
    .done         (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic program_word(input logic [7:0] w, input logic [3:0] g);
    palavra = w;
    gap = g;
    setar_palavra = 1'b1;
    tick();
    setar_palavra = 1'b0;
  endtask

  task automatic launch();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    start = 1'b0;
    setar_palavra = 1'b0;
    bit_ready = 1'b1;
    do_reset();
    checks++;
    if ({bit_out, bit_valid, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_outputs got out/valid/busy/done=%b want=0000",
               {bit_out, bit_valid, busy, done});
    end
  endtask

  task automatic test_word_no_gap();
    logic [7:0] w;
    w = 8'hB4;
    do_reset();
    program_word(w, 4'd0);
    launch();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({bit_valid, bit_out, busy, done} !== {1'b1, w[7-i], 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL b4_bit%0d got valid/out/busy/done=%b want=%b", i,
                 {bit_valid, bit_out, busy, done}, {1'b1, w[7-i], 1'b1, 1'b0});
      end
      tick();
    end
    checks++;
    if ({bit_valid, busy, done} !== 3'b001) begin
      failures++;
      $display("FAIL b4_done got valid/busy/done=%b want=001", {bit_valid, busy, done});
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL b4_done_pulse got done=%b want=0", done);
    end
  endtask

  task automatic test_gap_filler();
    logic [10:0] s;
    s = 11'b101_1111_1111;
    do_reset();
    program_word(8'hFF, 4'd3);
    launch();
    for (int i = 0; i < 11; i++) begin
      checks++;
      if ({bit_valid, bit_out, busy, done} !== {1'b1, s[10-i], 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL gap3_bit%0d got valid/out/busy/done=%b want=%b", i,
                 {bit_valid, bit_out, busy, done}, {1'b1, s[10-i], 1'b1, 1'b0});
      end
      tick();
    end
    checks++;
    if ({bit_valid, busy, done} !== 3'b001) begin
      failures++;
      $display("FAIL gap3_done got valid/busy/done=%b want=001", {bit_valid, busy, done});
    end
  endtask

  task automatic test_stall();
    logic [12:0] s;
    logic [9:0]  t;
    // Gap-3 frame of FFs, stalled two cycles on the third word bit.
    s = 13'b101_1111111111;
    do_reset();
    program_word(8'hFF, 4'd3);
    launch();
    for (int c = 0; c < 13; c++) begin
      bit_ready = !(c == 5 || c == 6);
      checks++;
      if ({bit_valid, bit_out, busy, done} !== {1'b1, s[12-c], 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL stall_ff_c%0d got valid/out/busy/done=%b want=%b", c,
                 {bit_valid, bit_out, busy, done}, {1'b1, s[12-c], 1'b1, 1'b0});
      end
      tick();
    end
    bit_ready = 1'b1;
    checks++;
    if ({bit_valid, busy, done} !== 3'b001) begin
      failures++;
      $display("FAIL stall_ff_done got valid/busy/done=%b want=001", {bit_valid, busy, done});
    end
    // B4 with no gap, stalled on the '0' second bit: 1,0,0,0,1,1,0,1,0,0.
    t = 10'b1000110100;
    program_word(8'hB4, 4'd0);
    launch();
    for (int c = 0; c < 10; c++) begin
      bit_ready = !(c == 1 || c == 2);
      checks++;
      if ({bit_valid, bit_out, done} !== {1'b1, t[9-c], 1'b0}) begin
        failures++;
        $display("FAIL stall_b4_c%0d got valid/out/done=%b want=%b", c,
                 {bit_valid, bit_out, done}, {1'b1, t[9-c], 1'b0});
      end
      tick();
    end
    bit_ready = 1'b1;
    checks++;
    if ({bit_valid, busy, done} !== 3'b001) begin
      failures++;
      $display("FAIL stall_b4_done got valid/busy/done=%b want=001", {bit_valid, busy, done});
    end
  endtask

  task automatic test_setar_abort();
    logic [7:0] w;
    logic       bad;
    w = 8'h0F;
    do_reset();
    program_word(8'hB4, 4'd0);
    launch();
    tick();
    tick();
    tick();
    palavra = w;
    gap = 4'd0;
    setar_palavra = 1'b1;
    tick();
    setar_palavra = 1'b0;
    checks++;
    if ({bit_valid, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL abort_next got valid/busy/done=%b want=000", {bit_valid, busy, done});
    end
    bad = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (done !== 1'b0 || bit_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      failures++;
      $display("FAIL abort_quiet got activity=%b want=0", bad);
    end
    launch();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({bit_valid, bit_out, done} !== {1'b1, w[7-i], 1'b0}) begin
        failures++;
        $display("FAIL abort_new_bit%0d got valid/out/done=%b want=%b", i,
                 {bit_valid, bit_out, done}, {1'b1, w[7-i], 1'b0});
      end
      tick();
    end
    checks++;
    if ({bit_valid, busy, done} !== 3'b001) begin
      failures++;
      $display("FAIL abort_new_done got valid/busy/done=%b want=001", {bit_valid, busy, done});
    end
  endtask

  task automatic test_rst_mid_gap();
    logic [2:0] f;
    f = 3'b101;
    do_reset();
    program_word(8'hFF, 4'd3);
    launch();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({bit_out, bit_valid, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL rst_mid_gap got out/valid/busy/done=%b want=0000",
               {bit_out, bit_valid, busy, done});
    end
    program_word(8'hFF, 4'd3);
    launch();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bit_valid, bit_out} !== {1'b1, f[2-i]}) begin
        failures++;
        $display("FAIL rst_reseed_filler%0d got valid/out=%b want=%b", i,
                 {bit_valid, bit_out}, {1'b1, f[2-i]});
      end
      tick();
    end
    for (int i = 0; i < 9; i++) tick();
  endtask

  task automatic test_loopback();
    logic [7:0] w;
    logic [7:0] det;
    w = 8'hB4;
    det = 8'h00;
    do_reset();
    program_word(w, 4'd0);
    launch();
    for (int i = 0; i < 8; i++) begin
      if (bit_valid && bit_ready) det = {det[6:0], bit_out};
      checks++;
      if ((det == w) !== (i == 7)) begin
        failures++;
        $display("FAIL loopback_match_bit%0d got match=%b want=%b", i, (det == w), (i == 7));
      end
      tick();
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL loopback_done got done=%b want=1", done);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    w = 8'hB4;
    do_reset();
    program_word(w, 4'd0);
    start = 1'b1;
    tick();
`ifdef SEQ_TX_REPEAT_EN
    for (int c = 0; c < 16; c++) begin
      checks++;
      if ({bit_valid, bit_out, busy, done} !== {1'b1, w[7-(c%8)], 1'b1, (c == 8)}) begin
        failures++;
        $display("FAIL repeat_c%0d got valid/out/busy/done=%b want=%b", c,
                 {bit_valid, bit_out, busy, done}, {1'b1, w[7-(c%8)], 1'b1, (c == 8)});
      end
      if (c == 15) start = 1'b0;
      tick();
    end
    checks++;
    if ({bit_valid, busy, done} !== 3'b001) begin
      failures++;
      $display("FAIL repeat_end got valid/busy/done=%b want=001", {bit_valid, busy, done});
    end
`else
    for (int c = 0; c < 8; c++) begin
      checks++;
      if ({bit_valid, bit_out, done} !== {1'b1, w[7-c], 1'b0}) begin
        failures++;
        $display("FAIL held_start_c%0d got valid/out/done=%b want=%b", c,
                 {bit_valid, bit_out, done}, {1'b1, w[7-c], 1'b0});
      end
      tick();
    end
    checks++;
    if ({bit_valid, busy, done} !== 3'b001) begin
      failures++;
      $display("FAIL held_start_done got valid/busy/done=%b want=001", {bit_valid, busy, done});
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if ({bit_valid, busy} !== 2'b00) begin
        failures++;
        $display("FAIL held_start_idle%0d got valid/busy=%b want=00", c, {bit_valid, busy});
      end
    end
    start = 1'b0;
    tick();
    launch();
    checks++;
    if ({bit_valid, bit_out, busy} !== 3'b111) begin
      failures++;
      $display("FAIL held_start_relaunch got valid/out/busy=%b want=111", {bit_valid, bit_out, busy});
    end
`endif
    start = 1'b0;
  endtask

  initial begin
    test_reset();
    test_word_no_gap();
    test_gap_filler();
    test_stall();
    test_setar_abort();
    test_rst_mid_gap();
    test_loopback();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sequence_transmitter.md
# sequence_transmitter

Serial bit-sequence generator: holds a programmed 8-bit word and emits it MSB-first on a one-bit stream, optionally preceded by a programmable run of pseudo-random filler bits. It is the transmitting end of the team's serial sequence-detector path: its output feeds the detector's serial bit input to produce test and loopback traffic. A valid/ready handshake lets the consumer stall the stream.

## Interface
- WORD_W, 8, word length in bits; the only supported value is 8.
- GAP_W, 4, width of the filler-count field.
- LFSR_SEED, 8'hA5, filler LFSR value after reset.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- setar_palavra  in  1  load `palavra` and `gap` this cycle.
- palavra  in  8  word to transmit.
- gap  in  GAP_W  number of filler bits before the word (0–15).
- start  in  1  frame request.
- bit_ready  in  1  consumer accepts `bit_out` this cycle.
- bit_out  out  1  current serial bit.
- bit_valid  out  1  `bit_out` holds a frame bit.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse after the last word bit is accepted.

## Operation
- Reset values:
  - Outputs: bit_out=0, bit_valid=0, busy=0, done=0.
  - Internal: word_reg=0, gap_reg=0, lfsr=LFSR_SEED, state=IDLE, start_q=0.
- States:
  - IDLE: bit_valid=0, busy=0.
  - GAP: emits filler bits.
  - WORD: emits word_reg[idx], with idx running from 7 down to 0.
- Transfer: a transfer occurs in a cycle where bit_valid && bit_ready. bit_out and bit_valid are registered and stay stable until the transfer.
- Priority (highest first): rst, setar_palavra, start.
  - setar_palavra in any state loads word_reg/gap_reg, forces IDLE, clears bit_valid and busy, and produces no done pulse. An in-flight frame is aborted.
- Launch: in IDLE, a rising edge of start (start && !start_q) with no setar_palavra launches a frame:
  - goes to GAP if gap_reg≠0, else to WORD;
  - sets idx=7;
  - loads the gap counter with gap_reg.
- GAP state:
  - Filler bit = lfsr[7].
  - On each GAP transfer: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]} and the gap counter decrements.
  - After the gap_reg-th transfer, go to WORD.
  - The LFSR never resets between frames, only on rst.
- WORD state:
  - Each transfer decrements idx.
  - The transfer at idx=0 ends the frame: the next cycle has done=1 and the state is IDLE (or a restart; see Configuration).
- idx is 3 bits. The 7→0 countdown is exact; there is no wrap past 0.

## Timing
- start edge sampled in cycle N → bit_valid=busy=1 and the first bit on bit_out in cycle N+1.
- With bit_ready held 1, a frame occupies gap_reg+8 cycles. done is high in cycle N+1+gap_reg+8, and busy=0 in that same cycle.
- bit_ready low for k cycles stretches the frame by k. The held bit does not change.
- A new frame can launch no earlier than the cycle done is high, and only on a fresh start edge.
- setar_palavra affects outputs in the following cycle. Reset behaves the same way.

## Configuration
- SEQ_TX_REPEAT_EN defined:
  - If start is high on the cycle of the final word transfer, the next cycle begins a new frame immediately (GAP or WORD, idx=7), with bit_valid continuous.
  - done still pulses once per frame, overlapping the new frame's first bit.
  - No start edge is needed for back-to-back frames.
- Undefined: each frame needs a new start rising edge, and IDLE always follows a frame.

## Structure
- Package seq_pkg holds:
  - the state enum (IDLE, GAP, WORD);
  - WORD_W and LFSR_SEED;
  - the LFSR tap mask 8'hB8.
- Sub-module seq_lfsr: 8-bit Fibonacci LFSR with synchronous load-seed and advance-enable ports, and output of bit 7.
- Top level: state register, gap counter, idx counter, start edge detector, output registers.

## Test plan
- palavra=8'hB4, gap=0, ready=1, start edge at N → bit_out 1,0,1,1,0,1,0,0 in N+1..N+8; done=1 and busy=0 at N+9.
- palavra=8'hFF, gap=3 after reset → filler 1,0,1 (LFSR A5→4A→95), then eight 1s; done at N+12.
- Same frame with bit_ready=0 for 2 cycles at the third word bit → that bit is held for 3 cycles total; done is 2 cycles later.
- setar_palavra (palavra=8'h0F) at the fourth word bit → bit_valid=0 next cycle, no done. A new start sends 0,0,0,0,1,1,1,1.
- rst asserted mid-GAP → all outputs 0 next cycle, and the next frame's filler again starts 1,0,1.
- Loopback: bit_out → detector bit input, with the detector enabled on bit_valid&&bit_ready and the same word programmed → detector match flag rises exactly after the 8th word bit. With SEQ_TX_REPEAT_EN and start held, there are two back-to-back frames with no bit_valid gap.
